// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and constants
// for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_OFFSET = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction,
// adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= ADJ_THRESH)
                 ? i_digit + ADJ_OFFSET
                 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: shift-and-add-3 binary to BCD
// converter, fixed latency of BIN_W shift cycles.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BIN_W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t r_state;
  state_t w_next;

  logic [AW-1:0]       r_acc;
  logic [BIN_W-1:0]    r_sh;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf_trk;
  logic [AW-1:0]       r_bcd;
  logic                r_ovf;

  logic [AW-1:0]       w_adj;
  logic [AW+BIN_W-1:0] w_cat;
  logic [AW-1:0]       w_acc_nx;
  logic [BIN_W-1:0]    w_sh_nx;
  logic                w_carry;
  logic                w_accept;
  logic                w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  assign w_cat    = {w_adj, r_sh} << 1;
  assign w_acc_nx = w_cat[AW+BIN_W-1:BIN_W];
  assign w_sh_nx  = w_cat[BIN_W-1:0];
  assign w_carry  = w_adj[AW-1];
  assign w_accept = start & ready;
  assign w_last   = (r_state == S_SHIFT)
                  && (r_cnt == CNT_ONE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_ONE) w_next = S_DONE;
      S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs decoded straight from state
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (r_state)
      S_IDLE:  ready = 1'b1;
      S_SHIFT: busy  = 1'b1;
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // load operand on accept, then adjust-and-shift
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_ovf_trk <= 1'b0;
    end else if (w_accept) begin
      r_acc     <= '0;
      r_sh      <= bin;
      r_cnt     <= CNT_LOAD;
      r_ovf_trk <= 1'b0;
    end else if (busy) begin
      r_acc     <= w_acc_nx;
      r_sh      <= w_sh_nx;
      r_cnt     <= r_cnt - CNT_ONE;
      r_ovf_trk <= r_ovf_trk | w_carry;
    end
  end

  // capture result on the final shift only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd <= '0;
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_bcd <= w_acc_nx;
      r_ovf <= r_ovf_trk | w_carry;
    end
  end

  assign bcd = r_bcd;
  assign ovf = r_ovf;

endmodule
